// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM customer-side session driver.
package atm_pkg;

    localparam int STEP_W = 3;

    localparam logic [3:0] KEY_ENTER  = 4'd10;
    localparam logic [3:0] KEY_CANCEL = 4'd11;

    typedef enum logic [3:0] {
        IDLE, CARD, LANG, PIN, AMT, CONF, WAIT, RECV, EJECT, RETAIN
    } state_t;

    // EJECT and RETAIN sit at level 0 so every step output drops on leaving a session.
    function automatic logic [STEP_W-1:0] step_level(input state_t s);
        logic [STEP_W-1:0] l;
        case (s)
            CARD:    l = 3'd1;
            LANG:    l = 3'd2;
            PIN:     l = 3'd3;
            AMT:     l = 3'd4;
            CONF:    l = 3'd5;
            WAIT:    l = 3'd6;
            RECV:    l = 3'd7;
            default: l = 3'd0;
        endcase
        return l;
    endfunction

    function automatic logic [6:0] thermo(input logic [STEP_W-1:0] l);
        logic [6:0] t;
        for (int i = 0; i < 7; i++) t[i] = (i < int'(l));
        return t;
    endfunction

endpackage

// File: rtl/atm_key_entry.sv
// Keypad digit handling: 4-digit PIN shift buffer with compare, and a
// decimal amount accumulator that refuses digits pushing it past MAX_AMOUNT.
module atm_key_entry #(
    parameter logic [15:0] PIN_CODE   = 16'h1234,
    parameter int          AMT_W      = 14,
    parameter int          MAX_AMOUNT = 10000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             digit_valid,
    input  logic [3:0]       digit,
    input  logic             pin_shift,
    input  logic             amt_shift,
    input  logic             clear_buf,
    input  logic             clear_amt,
    output logic             pin_ok,
    output logic [AMT_W-1:0] amount
);

    localparam int ACC_W = AMT_W + 4;

    logic [15:0]      pin_buf;
    logic [2:0]       pin_cnt;
    logic [ACC_W-1:0] acc;
    logic             acc_ok;

    // Extra 4 bits hold amount*10+9 without wrapping before the limit test.
    always_comb begin
        acc    = ({4'b0, amount} << 3) + ({4'b0, amount} << 1) + ACC_W'(digit);
        acc_ok = (acc <= ACC_W'(MAX_AMOUNT));
    end

    assign pin_ok = (pin_cnt == 3'd4) && (pin_buf == PIN_CODE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pin_buf <= '0;
            pin_cnt <= '0;
            amount  <= '0;
        end else begin
            if (clear_buf) begin
                pin_buf <= '0;
                pin_cnt <= '0;
            end else if (pin_shift && digit_valid && (pin_cnt < 3'd4)) begin
                pin_buf <= {pin_buf[11:0], digit};
                pin_cnt <= pin_cnt + 3'd1;
            end

            if (clear_amt)
                amount <= '0;
            else if (amt_shift && digit_valid && acc_ok)
                amount <= acc[AMT_W-1:0];
        end
    end

endmodule

// File: rtl/atm_session_driver.sv
// ATM session FSM: card/keypad to cumulative step levels for the controller core.
// Define ATM_SESSION_TIMEOUT_EN to add an inactivity eject in CARD..AMT.
module atm_session_driver
    import atm_pkg::*;
#(
    parameter logic [15:0] PIN_CODE    = 16'h1234,
    parameter int          MAX_TRIES   = 3,
    parameter int          AMT_W       = 14,
    parameter int          MAX_AMOUNT  = 10000,
    parameter int          WAIT_CYCLES = 8,
    parameter int          DONE_HOLD   = 4
`ifdef ATM_SESSION_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYCLES = 64
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             card_detect,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    input  logic             atm_out,
    output logic             card_insert,
    output logic             language,
    output logic             type_of_account,
    output logic             enter_pin,
    output logic             enter_amount,
    output logic             wait_while,
    output logic             receive_amount,
    output logic [AMT_W-1:0] amount,
    output logic [1:0]       tries_left,
    output logic             card_retained,
    output logic             eject,
    output logic             session_err
);

    localparam int CNT_MAX = (WAIT_CYCLES > DONE_HOLD) ? WAIT_CYCLES : DONE_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state_q, state_d;
    logic [1:0]       tries_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       steps_q;
    logic             err_d;
    logic             clear_buf, clear_amt, pin_ok;
    logic             is_digit, is_enter, is_cancel, is_sel, in_session;

    assign is_digit   = key_valid && (key_code <= 4'd9);
    assign is_enter   = key_valid && (key_code == KEY_ENTER);
    assign is_cancel  = key_valid && (key_code == KEY_CANCEL);
    assign is_sel     = key_valid && ((key_code == 4'd1) || (key_code == 4'd2));
    assign in_session = state_q inside {[CARD:RECV]};

    atm_key_entry #(
        .PIN_CODE  (PIN_CODE),
        .AMT_W     (AMT_W),
        .MAX_AMOUNT(MAX_AMOUNT)
    ) u_key_entry (
        .clk        (clk),
        .reset      (reset),
        .digit_valid(is_digit),
        .digit      (key_code),
        .pin_shift  (state_q == PIN),
        .amt_shift  (state_q == AMT),
        .clear_buf  (clear_buf),
        .clear_amt  (clear_amt),
        .pin_ok     (pin_ok),
        .amount     (amount)
    );

`ifdef ATM_SESSION_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_q;
    logic            to_expire;

    assign to_expire = (to_q == TO_W'(TIMEOUT_CYCLES - 1)) && !key_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            to_q <= '0;
        else if (key_valid || (state_d != state_q) || !(state_q inside {[CARD:AMT]}))
            to_q <= '0;
        else
            to_q <= to_q + TO_W'(1);
    end
`endif

    always_comb begin
        state_d   = state_q;
        tries_d   = tries_left;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        clear_buf = 1'b0;
        clear_amt = 1'b0;

        // Card removal wins over any key or dispense condition in the same cycle.
        if (in_session && !card_detect) begin
            state_d   = IDLE;
            err_d     = 1'b1;
            clear_buf = 1'b1;
            clear_amt = 1'b1;
        end else begin
            case (state_q)
                IDLE: if (card_detect) begin
                    state_d   = CARD;
                    tries_d   = 2'(MAX_TRIES);
                    clear_buf = 1'b1;
                    clear_amt = 1'b1;
                end
                CARD, LANG: if (is_cancel) begin
                    state_d   = EJECT;
                    clear_buf = 1'b1;
                    clear_amt = 1'b1;
                end else if (is_sel) begin
                    state_d = (state_q == CARD) ? LANG : PIN;
                end
                PIN: if (is_cancel) begin
                    state_d   = EJECT;
                    clear_buf = 1'b1;
                    clear_amt = 1'b1;
                end else if (is_enter) begin
                    clear_buf = 1'b1;
                    if (pin_ok) begin
                        state_d = AMT;
                    end else begin
                        tries_d = tries_left - 2'd1;
                        if (tries_left <= 2'd1) state_d = RETAIN;
                    end
                end
                AMT: if (is_cancel) begin
                    state_d   = EJECT;
                    clear_buf = 1'b1;
                    clear_amt = 1'b1;
                end else if (is_enter && (amount != '0)) begin
                    state_d = CONF;
                end
                CONF: begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                end
                WAIT: if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (atm_out) begin
                    state_d = RECV;
                    cnt_d   = CNT_W'(DONE_HOLD - 1);
                end
                RECV: if (cnt_q == '0)
                    state_d = EJECT;
                else
                    cnt_d = cnt_q - CNT_W'(1);
                EJECT: if (!card_detect) begin
                    state_d   = IDLE;
                    clear_amt = 1'b1;
                end
                RETAIN: if (!card_detect) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

`ifdef ATM_SESSION_TIMEOUT_EN
        if (to_expire && (state_q inside {[CARD:AMT]}) && (state_d == state_q)) begin
            state_d   = EJECT;
            clear_buf = 1'b1;
            clear_amt = 1'b1;
        end
`endif
    end

    // Outputs are registered from the next state so they change right after the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            tries_left    <= 2'(MAX_TRIES);
            cnt_q         <= '0;
            steps_q       <= '0;
            eject         <= 1'b0;
            card_retained <= 1'b0;
            session_err   <= 1'b0;
        end else begin
            state_q       <= state_d;
            tries_left    <= tries_d;
            cnt_q         <= cnt_d;
            steps_q       <= thermo(step_level(state_d));
            eject         <= (state_d == EJECT);
            card_retained <= (state_d == RETAIN);
            session_err   <= err_d;
        end
    end

    assign card_insert     = steps_q[0];
    assign language        = steps_q[1];
    assign type_of_account = steps_q[2];
    assign enter_pin       = steps_q[3];
    assign enter_amount    = steps_q[4];
    assign wait_while      = steps_q[5];
    assign receive_amount  = steps_q[6];

endmodule

// File: tb/tb_atm_session_driver.sv
// Directed table-driven bench for atm_session_driver (default build, no timeout).
module tb_atm_session_driver;

    logic        clk, reset, card_detect, key_valid, atm_out;
    logic [3:0]  key_code;
    logic        card_insert, language, type_of_account, enter_pin, enter_amount;
    logic        wait_while, receive_amount, card_retained, eject, session_err;
    logic [13:0] amount;
    logic [1:0]  tries_left;
    logic [6:0]  steps;

    int n_tests = 0;
    int n_fail  = 0;

    atm_session_driver dut (
        .clk(clk), .reset(reset), .card_detect(card_detect), .key_valid(key_valid),
        .key_code(key_code), .atm_out(atm_out), .card_insert(card_insert),
        .language(language), .type_of_account(type_of_account), .enter_pin(enter_pin),
        .enter_amount(enter_amount), .wait_while(wait_while),
        .receive_amount(receive_amount), .amount(amount), .tries_left(tries_left),
        .card_retained(card_retained), .eject(eject), .session_err(session_err)
    );

    assign steps = {receive_amount, wait_while, enter_amount, enter_pin,
                    type_of_account, language, card_insert};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       kv;
        logic [3:0] kc;
        logic       cd;
        logic       ao;
        int         lvl;
        int         amt;
        int         tries;
        logic       ej;
        logic       ret;
        logic       err;
    } row_t;

    row_t rows[$];

    function automatic void r(input logic kv, input logic [3:0] kc, input logic cd,
                              input logic ao, input int lvl, input int amt, input int tries,
                              input logic ej, input logic ret, input logic err);
        row_t x;
        x = '{kv, kc, cd, ao, lvl, amt, tries, ej, ret, err};
        rows.push_back(x);
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic apply(input logic kv, input logic [3:0] kc, input logic cd, input logic ao);
        key_valid   = kv;
        key_code    = kc;
        card_detect = cd;
        atm_out     = ao;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int lvl, input int amt, input int tries,
                             input logic ej, input logic ret, input logic err);
        logic [6:0] es;
        es = 7'((1 << lvl) - 1);
        check({tag, " steps"}, 32'(steps), 32'(es));
        check({tag, " amount"}, 32'(amount), amt);
        check({tag, " tries"}, 32'(tries_left), tries);
        check({tag, " eject"}, 32'(eject), 32'(ej));
        check({tag, " retained"}, 32'(card_retained), 32'(ret));
        check({tag, " err"}, 32'(session_err), 32'(err));
    endtask

    initial begin
        logic got_recv;

        // Happy path: PIN 1234, amount 500, dispense acknowledged.
        r(0, 0, 1, 0, 1, 0, 3, 0, 0, 0);
        r(1, 1, 1, 0, 2, 0, 3, 0, 0, 0);
        r(1, 2, 1, 0, 3, 0, 3, 0, 0, 0);
        r(1, 1, 1, 0, 3, 0, 3, 0, 0, 0);
        r(1, 2, 1, 0, 3, 0, 3, 0, 0, 0);
        r(1, 3, 1, 0, 3, 0, 3, 0, 0, 0);
        r(1, 4, 1, 0, 3, 0, 3, 0, 0, 0);
        r(1, 10, 1, 0, 4, 0, 3, 0, 0, 0);
        r(1, 5, 1, 0, 4, 5, 3, 0, 0, 0);
        r(1, 0, 1, 0, 4, 50, 3, 0, 0, 0);
        r(1, 0, 1, 0, 4, 500, 3, 0, 0, 0);
        r(1, 13, 1, 0, 4, 500, 3, 0, 0, 0);
        r(0, 10, 1, 0, 4, 500, 3, 0, 0, 0);
        r(1, 10, 1, 1, 5, 500, 3, 0, 0, 0);
        for (int i = 0; i < 8; i++) r(0, 0, 1, 1, 6, 500, 3, 0, 0, 0);
        for (int i = 0; i < 4; i++) r(0, 0, 1, 1, 7, 500, 3, 0, 0, 0);
        r(0, 0, 1, 1, 0, 500, 3, 1, 0, 0);
        r(0, 0, 1, 1, 0, 500, 3, 1, 0, 0);
        r(0, 0, 0, 0, 0, 0, 3, 0, 0, 0);

        // PIN lockout: wrong 4-digit, short 3-digit, wrong 4-digit.
        r(0, 0, 1, 0, 1, 0, 3, 0, 0, 0);
        r(1, 2, 1, 0, 2, 0, 3, 0, 0, 0);
        r(1, 1, 1, 0, 3, 0, 3, 0, 0, 0);
        for (int i = 0; i < 4; i++) r(1, 1, 1, 0, 3, 0, 3, 0, 0, 0);
        r(1, 10, 1, 0, 3, 0, 2, 0, 0, 0);
        for (int i = 1; i <= 3; i++) r(1, 4'(i), 1, 0, 3, 0, 2, 0, 0, 0);
        r(1, 10, 1, 0, 3, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) r(1, 1, 1, 0, 3, 0, 1, 0, 0, 0);
        r(1, 10, 1, 0, 0, 0, 0, 0, 1, 0);
        r(0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Fifth PIN digit ignored; ENTER at amount 0 ignored; saturation at 9999; CANCEL in AMT.
        r(0, 0, 1, 0, 1, 0, 3, 0, 0, 0);
        r(1, 1, 1, 0, 2, 0, 3, 0, 0, 0);
        r(1, 1, 1, 0, 3, 0, 3, 0, 0, 0);
        for (int i = 1; i <= 5; i++) r(1, 4'(i), 1, 0, 3, 0, 3, 0, 0, 0);
        r(1, 10, 1, 0, 4, 0, 3, 0, 0, 0);
        r(1, 10, 1, 0, 4, 0, 3, 0, 0, 0);
        r(1, 9, 1, 0, 4, 9, 3, 0, 0, 0);
        r(1, 9, 1, 0, 4, 99, 3, 0, 0, 0);
        r(1, 9, 1, 0, 4, 999, 3, 0, 0, 0);
        r(1, 9, 1, 0, 4, 9999, 3, 0, 0, 0);
        r(1, 9, 1, 0, 4, 9999, 3, 0, 0, 0);
        r(1, 11, 1, 0, 0, 0, 3, 1, 0, 0);
        r(0, 0, 0, 0, 0, 0, 3, 0, 0, 0);

        // Exactly MAX_AMOUNT accepted; WAIT without ack; CANCEL in WAIT ignored; pull card.
        r(0, 0, 1, 0, 1, 0, 3, 0, 0, 0);
        r(1, 2, 1, 0, 2, 0, 3, 0, 0, 0);
        r(1, 2, 1, 0, 3, 0, 3, 0, 0, 0);
        for (int i = 1; i <= 4; i++) r(1, 4'(i), 1, 0, 3, 0, 3, 0, 0, 0);
        r(1, 10, 1, 0, 4, 0, 3, 0, 0, 0);
        r(1, 1, 1, 0, 4, 1, 3, 0, 0, 0);
        r(1, 0, 1, 0, 4, 10, 3, 0, 0, 0);
        r(1, 0, 1, 0, 4, 100, 3, 0, 0, 0);
        r(1, 0, 1, 0, 4, 1000, 3, 0, 0, 0);
        r(1, 0, 1, 0, 4, 10000, 3, 0, 0, 0);
        r(1, 0, 1, 0, 4, 10000, 3, 0, 0, 0);
        r(1, 10, 1, 0, 5, 10000, 3, 0, 0, 0);
        for (int i = 0; i < 11; i++) r(0, 0, 1, 0, 6, 10000, 3, 0, 0, 0);
        r(1, 11, 1, 0, 6, 10000, 3, 0, 0, 0);
        r(0, 0, 0, 1, 0, 0, 3, 0, 0, 1);
        r(0, 0, 0, 0, 0, 0, 3, 0, 0, 0);

        // Removal outranks a same-cycle key; CANCEL in PIN after two digits.
        r(0, 0, 1, 0, 1, 0, 3, 0, 0, 0);
        r(1, 1, 0, 0, 0, 0, 3, 0, 0, 1);
        r(0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
        r(0, 0, 1, 0, 1, 0, 3, 0, 0, 0);
        r(1, 1, 1, 0, 2, 0, 3, 0, 0, 0);
        r(1, 1, 1, 0, 3, 0, 3, 0, 0, 0);
        r(1, 1, 1, 0, 3, 0, 3, 0, 0, 0);
        r(1, 2, 1, 0, 3, 0, 3, 0, 0, 0);
        r(1, 11, 1, 0, 0, 0, 3, 1, 0, 0);
        r(0, 0, 0, 0, 0, 0, 3, 0, 0, 0);

        reset = 1'b0; card_detect = 1'b0; key_valid = 1'b0; key_code = 4'd0; atm_out = 1'b0;
        #12;
        check_all("reset", 0, 0, 3, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        foreach (rows[i]) begin
            apply(rows[i].kv, rows[i].kc, rows[i].cd, rows[i].ao);
            check_all($sformatf("row%0d", i), rows[i].lvl, rows[i].amt, rows[i].tries,
                      rows[i].ej, rows[i].ret, rows[i].err);
        end

        // Asynchronous reset in the middle of RECV.
        apply(0, 0, 1, 0);
        apply(1, 1, 1, 0);
        apply(1, 1, 1, 0);
        for (int i = 1; i <= 4; i++) apply(1, 4'(i), 1, 0);
        apply(1, 10, 1, 0);
        apply(1, 7, 1, 0);
        apply(1, 10, 1, 1);
        got_recv = 1'b0;
        for (int i = 0; i < 20 && !got_recv; i++) begin
            apply(0, 0, 1, 1);
            got_recv = receive_amount;
        end
        check("reach_recv", 32'(got_recv), 32'd1);
        check("recv_amount", 32'(amount), 32'd7);
        apply(0, 0, 1, 1);
        #2 reset = 1'b0;
        #1;
        check_all("async_rst", 0, 0, 3, 1'b0, 1'b0, 1'b0);
        card_detect = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        apply(0, 0, 0, 0);
        check_all("post_rst", 0, 0, 3, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/atm_session_driver.md
Name: atm_session_driver

Overview:
- Customer-side front end for the ATM controller core.
- Converts a card-detect switch and keypad strobes into the cumulative step levels the core consumes: card_insert, language, type_of_account, enter_pin, enter_amount, wait_while, receive_amount.
- Validates the PIN, accumulates the withdrawal amount, and paces the wait/receive phases against the core's dispense acknowledge (atm_out).

Parameters:
PIN_CODE, 16'h1234, expected PIN as 4 BCD digits, most significant digit entered first
MAX_TRIES, 3, PIN attempts allowed per session (1..3)
AMT_W, 14, width of the amount register
MAX_AMOUNT, 10000, largest accepted amount
WAIT_CYCLES, 8, minimum cycles in the wait phase (>=1)
DONE_HOLD, 4, cycles receive_amount is held before eject (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
card_detect  in  1  card present level
key_valid  in  1  one-cycle keypad strobe
key_code  in  4  0-9 digit, 10 ENTER, 11 CANCEL, 12-15 ignored
atm_out  in  1  dispense acknowledge from the controller core
card_insert, language, type_of_account, enter_pin, enter_amount, wait_while, receive_amount  out  1 each  cumulative step levels
amount  out  AMT_W  accepted or in-progress amount
tries_left  out  2  remaining PIN attempts
card_retained  out  1  card captured after PIN lockout
eject  out  1  return-card request
session_err  out  1  one-cycle pulse on card removal mid-session

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous): state IDLE, all outputs 0, tries_left=MAX_TRIES.
- Step outputs form a thermometer of level L: bit i is high iff i<L, in the port order listed. No step output ever drops except by a transition to L=0.
- IDLE (L=0): card_detect=1 at a clock edge -> CARD; tries_left reloads to MAX_TRIES; amount cleared.
- CARD (L=1): key 1 or 2 -> LANG.
- LANG (L=2): key 1 or 2 -> PIN.
- PIN (L=3): each digit shifts into a 4-digit buffer; a 5th and later digit is ignored. On ENTER:
  - Exactly 4 digits equal PIN_CODE -> AMT.
  - Otherwise tries_left decrements and the buffer clears. If tries_left reaches 0 -> RETAIN.
- AMT (L=4): a digit d sets amount=amount*10+d only if the result is <=MAX_AMOUNT; otherwise the digit is ignored. ENTER with amount!=0 -> CONF. ENTER with amount==0 is ignored.
- CONF (L=5): unconditionally, one cycle later -> WAIT; wait counter loads WAIT_CYCLES-1.
- WAIT (L=6): counter decrements to 0 and holds. When counter==0 and atm_out==1 -> RECV. No upper time limit.
- RECV (L=7): held exactly DONE_HOLD cycles -> EJECT.
- EJECT (L=0): eject=1 until card_detect=0 -> IDLE; amount cleared on exit.
- RETAIN (L=0): card_retained=1 until card_detect=0 -> IDLE.
- CANCEL: in CARD, LANG, PIN or AMT -> EJECT; amount cleared. Ignored in CONF, WAIT and RECV.
- Card removal: card_detect=0 in any state CARD..RECV -> IDLE next edge, all outputs cleared, session_err pulses one cycle.
- Removal outranks a same-cycle key; it also outranks the WAIT->RECV condition.
- Latency: a qualifying input sampled at edge n changes the outputs after edge n. Keys with key_valid=0 or codes 12-15 have no effect.

Optional Feature:
- Macro: ATM_SESSION_TIMEOUT_EN.
- When defined: an inactivity counter (parameter TIMEOUT_CYCLES, default 64) runs in CARD, LANG, PIN and AMT.
  - It restarts on any key_valid and on every state change.
  - On expiry the block goes to EJECT, identical to CANCEL.
- When undefined: no counter exists and these states wait indefinitely.

Decomposition:
- Package atm_pkg holds:
  - State enumeration (IDLE, CARD, LANG, PIN, AMT, CONF, WAIT, RECV, EJECT, RETAIN).
  - Key-code constants (KEY_ENTER=10, KEY_CANCEL=11).
  - Step-level width constant (3).
- One sub-module, atm_key_entry:
  - Contains the digit shift buffer, digit count, PIN compare and saturating decimal amount accumulator.
  - Exposes pin_ok and amount to the top-level FSM.

Test Plan:
- Happy path:
  - Stimulus: card_detect=1; keys 1, 2, 1,2,3,4, ENTER, 5,0,0, ENTER; atm_out=1.
  - Response: L steps 1->2->3->4->5->6; receive_amount high 8 cycles after CONF; amount=500; eject after 4 cycles of L=7; IDLE once card_detect=0.
- PIN lockout:
  - Stimulus: three ENTERs with 1,1,1,1.
  - Response: tries_left 3->2->1->0; card_retained=1; all steps 0.
- Amount saturation:
  - Stimulus: digits 9,9,9,9,9.
  - Response: amount stops at 9999; fifth 9 ignored; ENTER with amount=0 is ignored.
- Card pulled in WAIT (atm_out=0):
  - Response: IDLE next cycle; session_err single pulse; steps all 0.
- CANCEL:
  - Stimulus: CANCEL in PIN after 2 digits; separately, CANCEL in WAIT.
  - Response: PIN case -> EJECT, amount=0. WAIT case -> ignored, stays L=6.
- Asynchronous reset:
  - Stimulus: reset asserted mid-RECV.
  - Response: outputs 0 immediately, without waiting for a clock edge.
  - With ATM_SESSION_TIMEOUT_EN: no key for 64 cycles in LANG -> eject=1.
